// File: rtl/hamming_decoder_engine_if.sv
// Byte-wide synchronous memory port shared by the Hamming decoder engine and the core.
// Read data returns the cycle after mem_addr is presented.
interface hamming_decoder_engine_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [7:0]        mem_rd_data;

  modport master (
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/hamming_decoder_engine.sv
// SECDED Hamming(16,11) decoder engine: reads NUM_MSG codewords, writes message + error flag.
// Optional HAMMING_ERR_COUNT_EN adds single/double error counters.
module hamming_decoder_engine #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int ADDR_W   = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            done,
  hamming_decoder_engine_if.master        mem
`ifdef HAMMING_ERR_COUNT_EN
  ,
  output logic [4:0]                      single_cnt,
  output logic [4:0]                      double_cnt
`endif
);

  localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HI,
    S_RD_LO,
    S_CAPTURE,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               done_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               wr_en_q;
  logic [7:0]         wr_data_q;
  logic [7:0]         hi_q;
  logic [7:0]         dec_hi_q;
`ifdef HAMMING_ERR_COUNT_EN
  logic [4:0]         single_q;
  logic [4:0]         double_q;
`endif

  logic [ADDR_W-1:0]  src_lo_a;
  logic [ADDR_W-1:0]  dst_lo_a;
  logic [15:0]        cw;
  logic [15:0]        fix;
  logic [3:0]         syn;
  logic               par;
  logic [1:0]         flag;
  logic [7:0]         dec_lo_d;
  logic [7:0]         dec_hi_d;

  assign src_lo_a = ADDR_W'(SRC_BASE) + ADDR_W'({idx_q, 1'b0});
  assign dst_lo_a = ADDR_W'(DST_BASE) + ADDR_W'({idx_q, 1'b0});

  // Decode uses the live low byte during CAPTURE so the write data can be registered
  // on the same edge the low byte arrives.
  always_comb begin
    cw   = {hi_q, mem.mem_rd_data};
    syn  = '0;
    for (int unsigned j = 1; j < 16; j++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (j[k]) syn[k] = syn[k] ^ cw[j[3:0]];
      end
    end
    par  = ^cw;
    fix  = cw;
    flag = 2'b00;
    if (par) begin
      fix[syn] = ~cw[syn];
      flag     = 2'b01;
    end else if (syn != 4'd0) begin
      flag     = 2'b10;
    end
    dec_lo_d = {fix[12:9], fix[7:5], fix[3]};
    dec_hi_d = {flag, 3'b000, fix[15:13]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      hi_q      <= '0;
      dec_hi_q  <= '0;
`ifdef HAMMING_ERR_COUNT_EN
      single_q  <= '0;
      double_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          wr_en_q <= 1'b0;
          if (start) begin
            done_q  <= 1'b0;
            idx_q   <= '0;
            addr_q  <= ADDR_W'(SRC_BASE) + ADDR_W'(1);
            state_q <= S_RD_HI;
`ifdef HAMMING_ERR_COUNT_EN
            single_q <= '0;
            double_q <= '0;
`endif
          end
        end
        S_RD_HI: begin
          addr_q  <= src_lo_a;
          state_q <= S_RD_LO;
        end
        S_RD_LO: begin
          hi_q    <= mem.mem_rd_data;
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          wr_data_q <= dec_lo_d;
          dec_hi_q  <= dec_hi_d;
          addr_q    <= dst_lo_a;
          wr_en_q   <= 1'b1;
          state_q   <= S_WR_LO;
        end
        S_WR_LO: begin
          wr_data_q <= dec_hi_q;
          addr_q    <= dst_lo_a + ADDR_W'(1);
          state_q   <= S_WR_HI;
        end
        S_WR_HI: begin
`ifdef HAMMING_ERR_COUNT_EN
          if (wr_data_q[6]) single_q <= single_q + 5'd1;
          if (wr_data_q[7]) double_q <= double_q + 5'd1;
`endif
          idx_q   <= idx_q + IDX_W'(1);
          wr_en_q <= 1'b0;
          if (idx_q == IDX_W'(NUM_MSG - 1)) begin
            addr_q  <= '0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            addr_q  <= src_lo_a + ADDR_W'(3);
            state_q <= S_RD_HI;
          end
        end
        default: begin
          wr_en_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign done            = done_q;
  assign mem.mem_addr    = addr_q;
  assign mem.mem_wr_en   = wr_en_q;
  assign mem.mem_wr_data = wr_data_q;
`ifdef HAMMING_ERR_COUNT_EN
  assign single_cnt      = single_q;
  assign double_cnt      = double_q;
`endif

endmodule

// File: tb/tb_hamming_decoder_engine.sv
// Directed bench for hamming_decoder_engine with a byte-wide synchronous memory model.
module tb_hamming_decoder_engine;

  logic clk;
  logic reset;
  logic start;
  logic done;
`ifdef HAMMING_ERR_COUNT_EN
  logic [4:0] single_cnt;
  logic [4:0] double_cnt;
`endif

  hamming_decoder_engine_if #(.ADDR_W(8)) bus ();

  hamming_decoder_engine #(
    .NUM_MSG (15),
    .SRC_BASE(30),
    .DST_BASE(0),
    .ADDR_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem       (bus)
`ifdef HAMMING_ERR_COUNT_EN
    ,
    .single_cnt(single_cnt),
    .double_cnt(double_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with backdoor load port and per-address write counters.
  logic [7:0] mem_arr [256];
  int         wr_cnt  [256];
  int         total_wr;
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       clr;

  always @(posedge clk) begin
    bus.mem_rd_data <= mem_arr[bus.mem_addr];
    if (clr) begin
      for (int a = 0; a < 256; a++) wr_cnt[a] <= 0;
      total_wr <= 0;
    end else begin
      if (ld_en) mem_arr[ld_addr] <= ld_data;
      if (bus.mem_wr_en) begin
        mem_arr[bus.mem_addr] <= bus.mem_wr_data;
        wr_cnt[bus.mem_addr]  <= wr_cnt[bus.mem_addr] + 1;
        total_wr              <= total_wr + 1;
      end
    end
  end

  typedef struct {
    logic [15:0] cw;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  vec_t tbl [15];
  vec_t cur [15];

  int n_cmp;
  int n_err;

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic clear_counts();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic load_set(input bit zeros);
    for (int i = 0; i < 15; i++) begin
      if (zeros) cur[i] = '{16'h0000, 8'h00, 8'h00};
      else       cur[i] = tbl[i];
      poke(8'(30 + 2 * i), cur[i].cw[7:0]);
      poke(8'(31 + 2 * i), cur[i].cw[15:8]);
      poke(8'(2 * i), 8'hA5);
      poke(8'(2 * i + 1), 8'h5A);
    end
  endtask

  task automatic do_run(input bit pulse_mid, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    check("done_clr", 0, 16'(done), 16'h0);
    while (done !== 1'b1 && lat < 300) begin
      if (pulse_mid && lat == 20) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
    end
  endtask

  task automatic check_results();
    for (int i = 0; i < 15; i++) begin
      check("lo", i, 16'(mem_arr[2 * i]), 16'(cur[i].lo));
      check("hi", i, 16'(mem_arr[2 * i + 1]), 16'(cur[i].hi));
    end
  endtask

  int lat;
  int snap;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    start   = 1'b0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    clr     = 1'b0;

    tbl[0]  = '{16'h0000, 8'h00, 8'h00};
    tbl[1]  = '{16'hFFFF, 8'hFF, 8'h07};
    tbl[2]  = '{16'h7FFF, 8'hFF, 8'h47};
    tbl[3]  = '{16'h0200, 8'h00, 8'h40};
    tbl[4]  = '{16'h0001, 8'h00, 8'h40};
    tbl[5]  = '{16'h0003, 8'h00, 8'h80};
    tbl[6]  = '{16'h000F, 8'h01, 8'h00};
    tbl[7]  = '{16'h0007, 8'h01, 8'h40};
    tbl[8]  = '{16'h0009, 8'h01, 8'h80};
    tbl[9]  = '{16'h2000, 8'h00, 8'h40};
    tbl[10] = '{16'h3FFF, 8'hFF, 8'h81};
    tbl[11] = '{16'hFFFE, 8'hFF, 8'h47};
    tbl[12] = '{16'hFFEF, 8'hFF, 8'h47};
    tbl[13] = '{16'hFEFF, 8'hFF, 8'h47};
    tbl[14] = '{16'h1008, 8'h81, 8'h80};

    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 0, 16'(done), 16'h0);
    check("rst_wr_en", 0, 16'(bus.mem_wr_en), 16'h0);
    check("rst_addr", 0, 16'(bus.mem_addr), 16'h0);
    check("rst_wr_data", 0, 16'(bus.mem_wr_data), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    clear_counts();

    // Run A: all-zero codewords.
    load_set(1'b1);
    do_run(1'b0, lat);
    check("lat_zero", 0, 16'(lat), 16'd76);
    check_results();

    // Run B: mixed clean/single/double vectors, started from DONE.
    load_set(1'b0);
    do_run(1'b0, lat);
    check("lat_tbl", 0, 16'(lat), 16'd76);
    check_results();
`ifdef HAMMING_ERR_COUNT_EN
    check("single_cnt", 0, 16'(single_cnt), 16'd8);
    check("double_cnt", 0, 16'(double_cnt), 16'd4);
`endif

    // Run C: extra start mid-run must be ignored.
    load_set(1'b1);
    clear_counts();
    do_run(1'b1, lat);
    check("lat_midstart", 0, 16'(lat), 16'd76);
    repeat (3) @(posedge clk);
    #1;
    for (int a = 0; a < 30; a++) check("wr_once", a, 16'(wr_cnt[a]), 16'd1);
    check("total_wr", 0, 16'(total_wr), 16'd30);
    check_results();

    // Run D: reset at cycle 30 of a run, then a clean restart.
    load_set(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    snap = total_wr;
    check("abort_done", 0, 16'(done), 16'h0);
    check("abort_wr_en", 0, 16'(bus.mem_wr_en), 16'h0);
    check("abort_addr", 0, 16'(bus.mem_addr), 16'h0);
`ifdef HAMMING_ERR_COUNT_EN
    check("abort_single", 0, 16'(single_cnt), 16'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_no_wr", 0, 16'(total_wr - snap), 16'd0);
    check("idle_addr", 0, 16'(bus.mem_addr), 16'h0);
    check("idle_done", 0, 16'(done), 16'h0);
    do_run(1'b0, lat);
    check("lat_after_rst", 0, 16'(lat), 16'd76);
    check_results();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
